// File: rtl/adpcm_sample_fetch.sv
// Streams one ADPCM sample from SDRAM to a nibble-serial decoder: toggle-handshake word reads into a small FIFO, nibbles out.
// Optional: define ADPCM_FETCH_LOOP_EN to add the `loop` input (seamless restart from the start word after the end word).
module adpcm_sample_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] start_addr,
  input  logic [25:0] end_addr,
  input  logic        nib_rd,
  output logic [3:0]  nib_out,
  output logic        nib_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [25:0] mem_addr,
  input  logic [31:0] mem_q
`ifdef ADPCM_FETCH_LOOP_EN
  ,
  input  logic        loop
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [23:0]   start_word_q, start_word_d, end_word_q, end_word_d;
  logic [23:0]   fetch_word_q, fetch_word_d;
  logic          end_req_q, end_req_d, out_q, out_d, pend_last_q, pend_last_d;
  logic          mem_req_q, mem_req_d;
  logic [25:0]   mem_addr_q, mem_addr_d;
  logic [32:0]   fifo_q [FIFO_DEPTH];
  logic [32:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nib_out_q, nib_out_d;
  logic          nib_valid_q, nib_valid_d, busy_q, busy_d;
  logic          done_q, done_d, underrun_q, underrun_d;

  logic          ack_hit, restart, push, pop, fill_empty, loop_w;
  logic [31:0]   head_word;
  logic          unused_addr_bits;

`ifdef ADPCM_FETCH_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif

  assign unused_addr_bits = ^{start_addr[1:0], end_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    start_word_d = start_word_q;
    end_word_d   = end_word_q;
    fetch_word_d = fetch_word_q;
    end_req_d    = end_req_q;
    out_d        = out_q;
    pend_last_d  = pend_last_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    restart      = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    ack_hit = out_q && (mem_ack == mem_req_q);
    if (ack_hit) out_d = 1'b0;

    if (start) begin
      start_word_d = start_addr[25:2];
      end_word_d   = end_addr[25:2];
      fetch_word_d = start_addr[25:2];
      end_req_d    = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      idx_d        = '0;
      // A stale request still in flight must drain before the new stream can fetch.
      if (state_q == S_FLUSH) state_d = ack_hit ? S_RUN : S_FLUSH;
      else if (out_d)         state_d = S_FLUSH;
      else begin
        state_d = S_RUN;
        restart = 1'b1;
      end
    end else begin
      case (state_q)
        S_FLUSH: if (ack_hit) state_d = S_RUN;
        S_RUN: begin
          push = ack_hit;
          if (nib_rd && nib_valid_q) begin
            if (idx_q == 3'd7) begin
              pop   = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
      underrun_d = nib_rd && busy_q && !nib_valid_q;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = {pend_last_q, mem_q};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    if (pop && fifo_q[rd_ptr_q][32]) begin
      done_d   = 1'b1;
      state_d  = S_IDLE;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
    end

    // One request in flight; a fresh ack must be seen one cycle before the next issue.
    if (state_d == S_RUN && !end_req_d &&
        (restart || (state_q == S_RUN && !out_q && cnt_q < DEPTH_C))) begin
      mem_req_d  = ~mem_req_q;
      mem_addr_d = {fetch_word_d, 2'b00};
      out_d      = 1'b1;
      if (fetch_word_d == end_word_d) begin
        pend_last_d = !loop_w;
        if (loop_w) fetch_word_d = start_word_d;
        else begin
          end_req_d    = 1'b1;
          fetch_word_d = fetch_word_d + 24'd1;
        end
      end else begin
        pend_last_d  = 1'b0;
        fetch_word_d = fetch_word_d + 24'd1;
      end
    end

    // Word arriving into an empty FIFO becomes the head directly from mem_q.
    fill_empty  = push && (cnt_q == {{(CW-1){1'b0}}, pop});
    head_word   = fill_empty ? mem_q : fifo_q[rd_ptr_d][31:0];
    busy_d      = (state_d != S_IDLE);
    nib_valid_d = (state_d == S_RUN) && (cnt_d != '0);
    nib_out_d   = nib_valid_d ? head_word[{idx_d[2:1], ~idx_d[0], 2'b00} +: 4] : 4'd0;
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (reset) begin
      state_q      <= S_IDLE;
      start_word_q <= '0;
      end_word_q   <= '0;
      fetch_word_q <= '0;
      end_req_q    <= 1'b0;
      out_q        <= 1'b0;
      pend_last_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      nib_out_q    <= '0;
      nib_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_word_q <= start_word_d;
      end_word_q   <= end_word_d;
      fetch_word_q <= fetch_word_d;
      end_req_q    <= end_req_d;
      out_q        <= out_d;
      pend_last_q  <= pend_last_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      nib_out_q    <= nib_out_d;
      nib_valid_q  <= nib_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign nib_out   = nib_out_q;
  assign nib_valid = nib_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: doc/adpcm_sample_fetch.md
# adpcm_sample_fetch

Streams one ADPCM sample from SDRAM to a YM2610 ADPCM channel decoder. Sits directly upstream of the SDRAM controller's 32-bit sample port (`samplea`/`sampleb`): it issues toggle-handshake word reads and buffers the returned words in a small FIFO. It then hands the decoder one 4-bit nibble per `nib_rd` pulse, from the start word to the end word inclusive.

## Interface
- `FIFO_DEPTH`, default 4: buffered 32-bit words; power of two, 2..16.
- `clk` input 1: system clock, same clock as the SDRAM controller.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; latches `start_addr` and `end_addr` and begins playback.
- `start_addr` input 26: byte address of the first word; bits [1:0] are ignored.
- `end_addr` input 26: byte address of the last word, inclusive; bits [1:0] are ignored.
- `nib_rd` input 1: decoder consumes the current nibble.
- `nib_out` output 4: current nibble.
- `nib_valid` output 1: `nib_out` holds a valid nibble.
- `busy` output 1: a playback is active.
- `done` output 1: one-cycle pulse when the last nibble has been consumed.
- `underrun` output 1: one-cycle pulse when `nib_rd` arrives while `busy` is high and `nib_valid` is low.
- `mem_req` output 1: request toggle to the SDRAM controller.
- `mem_ack` input 1: ack toggle; a request is complete when `mem_ack == mem_req`.
- `mem_addr` output 26: `{fetch_word, 2'b00}`; held stable while a request is outstanding.
- `mem_q` input 32: read data; valid in the cycle `mem_ack` becomes equal to `mem_req`.
- `loop` input 1: present only with `ADPCM_FETCH_LOOP_EN` (see Configuration).

## Operation
- States:
  - IDLE: `busy` low.
  - RUN: fetching and/or supplying nibbles.
  - FLUSH: waiting for a stale request after a restart.
- Word counters are 24 bits and wrap from 0xFFFFFF to 0. If the end word is below the start word, playback runs through the wrap.
- Fetch rule in RUN: a request is issued when all of the following hold:
  - no request is outstanding;
  - `fifo_count < FIFO_DEPTH`;
  - the end word has not yet been requested.
- Issuing a request toggles `mem_req` and drives `mem_addr` from `fetch_word`. `fetch_word` increments when the request is issued.
- At most one request is outstanding.
- When `mem_ack == mem_req` while a request is outstanding, `mem_q` is pushed into the FIFO and the outstanding flag clears.
- Nibble order within a word: byte 0 (`mem_q[7:0]`) first, then bytes 1, 2, 3. Within each byte, the high nibble comes before the low nibble. That gives 8 nibbles per word.
- A 3-bit nibble index selects `nib_out` from the FIFO head.
- `nib_rd` with `nib_valid` high advances the index. On index 7 the head word is popped.
- Popping the end word ends playback: `done` pulses, `busy` falls and the state returns to IDLE.
- `nib_rd` with `nib_valid` low is ignored. If `busy` is high, `underrun` pulses.
- `start` in IDLE: latch the addresses, clear the FIFO and the nibble index, enter RUN.
- `start` in RUN with a request outstanding:
  - clear the FIFO, latch the new addresses, enter FLUSH;
  - in FLUSH the stale ack is awaited and its data discarded; the state then moves to RUN;
  - no new request is issued before the stale ack returns.
- `start` in RUN with no request outstanding: restart directly in RUN.
- `start` in FLUSH: latch the new addresses and stay in FLUSH.
- `start` takes priority over a simultaneous `nib_rd` and a simultaneous `mem_ack` push. `done` is not pulsed on a restart.
- Reset values:
  - `mem_req` 0;
  - `busy`, `nib_valid`, `done`, `underrun` 0;
  - `nib_out` 0, `mem_addr` 0;
  - FIFO empty, state IDLE, outstanding flag clear.
- `reset` does not wait for an outstanding ack. The SDRAM controller must be reset together with this block, so its ack state resets to 0 as well.

## Timing
- `start` at edge n: `busy` is high and `mem_req` toggles at edge n+1.
- Ack sampled equal at edge k: the word is written at edge k. `nib_valid` is high and `nib_out` shows nibble 0 from edge k+1.
- `nib_out` and `nib_valid` are registered. After a consuming `nib_rd` at edge m, the next nibble is visible from edge m+1.
- The next request can issue at edge k+1 after an ack at edge k. Fetch throughput is therefore one word per request-plus-ack latency, plus 1 cycle.
- FIFO full and push in the same cycle cannot occur, because the fetch rule reserves a slot for the outstanding request.
- A pop and a push in the same cycle leave the count unchanged.
- `done` pulses in the cycle after the final consuming `nib_rd`. `busy` is low in that same cycle.

## Configuration
- `ADPCM_FETCH_LOOP_EN` defined:
  - adds the `loop` input;
  - if `loop` is high when the end word is requested, `fetch_word` reloads the start word and fetching continues;
  - popping the end word then does not end playback and `done` is not pulsed; the stream continues seamlessly;
  - if `loop` is low at that point, playback ends as normal.
- `ADPCM_FETCH_LOOP_EN` undefined: no `loop` port; playback always ends after the end word.

## Test plan
- start_addr=0x000100, end_addr=0x000104 with a 3-cycle ack responder returning 0x76543210 then 0xFEDCBA98, and `nib_rd` held high:
  - nibbles are 1,0,3,2,5,4,7,6 then 9,8,B,A,D,C,F,E;
  - `done` pulses once after the 16th nibble; exactly 2 requests are issued.
- Decoder idle, FIFO_DEPTH=4, long sample: exactly 4 requests are issued, then `mem_req` holds. One full word consumed (8 `nib_rd`) produces exactly one further request.
- start_addr=0x3FFFFFC, end_addr=0x0000004: requests go to 0x3FFFFFC, 0x0000000, 0x0000004, then `done`.
- `start` with a 10-cycle-latency ack outstanding:
  - the stale `mem_q` is never output;
  - the first nibble comes from the new start_addr;
  - `mem_req` does not toggle before the stale ack.
- `nib_rd` while `nib_valid` is low during RUN: `underrun` pulses; the index does not advance.
- With `ADPCM_FETCH_LOOP_EN` and `loop`=1, 2-word sample: the word sequence repeats start, end, start, end, … with no `done` and no gap beyond the ack latency. Setting `loop`=0 causes `done` after the next end word.
